// File: rtl/cv_gen_seq_pkg.sv
// Shared mode encodings and default sequence table for cv_gen_seq_prm.
package cv_gen_seq_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DN   = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Reflected Gray code of i; callers truncate to the value width.
  function automatic logic [31:0] gray_default(input logic [31:0] i);
    return i ^ (i >> 1);
  endfunction

endpackage

// File: rtl/cv_seq_table.sv
// Sequence table: Gray-code ROM, or a writable register file when
// CV_GEN_SEQ_TABLE_WR_EN is defined.
module cv_seq_table
  import cv_gen_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

`ifdef CV_GEN_SEQ_TABLE_WR_EN

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= WIDTH'(gray_default(32'(i)));
    end else if (wr_en && (32'(wr_addr) < 32'(DEPTH))) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

`else

  logic unused_wr;

  assign rd_dat = WIDTH'(gray_default(32'(rd_addr)));
  assign unused_wr = ^{clk, rst, wr_en, wr_addr, wr_dat};

`endif

endmodule

// File: rtl/cv_gen_seq_prm.sv
// Windowed index sequencer (up/down/ping-pong/hold) over a value table.
// Table writes are enabled by defining CV_GEN_SEQ_TABLE_WR_EN.
module cv_gen_seq_prm
  import cv_gen_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STEP,
  input  logic             LOAD,
  input  logic [1:0]       MODE,
  input  logic [IDX_W-1:0] DAT_I,
  input  logic [IDX_W-1:0] LO,
  input  logic [IDX_W-1:0] HI,
  input  logic             WR_EN,
  input  logic [IDX_W-1:0] WR_ADDR,
  input  logic [WIDTH-1:0] WR_DAT,
  output logic [IDX_W-1:0] NOM,
  output logic [WIDTH-1:0] SEQ,
  output logic             WRAP
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(DEPTH - 1);

  logic [IDX_W-1:0] nom;
  logic             dir;
  logic             wrap;

  logic             full_win;
  logic [IDX_W-1:0] lo_eff;
  logic [IDX_W-1:0] hi_eff;
  logic             in_win;
  logic             ld_in_win;
  logic [IDX_W-1:0] nom_ld;
  logic [IDX_W-1:0] nom_st;
  logic             dir_st;
  logic             wrap_st;

  // An inverted or oversized window falls back to the whole table.
  assign full_win  = (LO > HI) || (HI > MAX_IDX);
  assign lo_eff    = full_win ? '0 : LO;
  assign hi_eff    = full_win ? MAX_IDX : HI;
  assign in_win    = (nom >= lo_eff) && (nom <= hi_eff);
  assign ld_in_win = (DAT_I >= lo_eff) && (DAT_I <= hi_eff);
  assign nom_ld    = ld_in_win ? DAT_I : lo_eff;

  always_comb begin
    nom_st  = nom;
    dir_st  = dir;
    wrap_st = 1'b0;
    unique case (MODE)
      MODE_UP: begin
        if (!in_win || nom == hi_eff) begin
          nom_st  = lo_eff;
          wrap_st = 1'b1;
        end else begin
          nom_st = nom + 1'b1;
        end
      end
      MODE_DN: begin
        if (!in_win || nom == lo_eff) begin
          nom_st  = hi_eff;
          wrap_st = 1'b1;
        end else begin
          nom_st = nom - 1'b1;
        end
      end
      MODE_PP: begin
        if (!in_win) begin
          nom_st  = lo_eff;
          dir_st  = DIR_UP;
          wrap_st = 1'b1;
        end else if (lo_eff == hi_eff) begin
          wrap_st = 1'b1;
        end else if (dir == DIR_UP) begin
          if (nom == hi_eff) begin
            nom_st  = nom - 1'b1;
            dir_st  = DIR_DN;
            wrap_st = 1'b1;
          end else begin
            nom_st = nom + 1'b1;
          end
        end else begin
          if (nom == lo_eff) begin
            nom_st  = nom + 1'b1;
            dir_st  = DIR_UP;
            wrap_st = 1'b1;
          end else begin
            nom_st = nom - 1'b1;
          end
        end
      end
      MODE_HOLD: begin
        nom_st = nom;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      nom  <= '0;
      dir  <= DIR_UP;
      wrap <= 1'b0;
    end else if (LOAD) begin
      nom  <= nom_ld;
      dir  <= DIR_UP;
      wrap <= 1'b0;
    end else if (STEP) begin
      nom  <= nom_st;
      dir  <= dir_st;
      wrap <= wrap_st;
    end else begin
      wrap <= 1'b0;
    end
  end

  assign NOM  = nom;
  assign WRAP = wrap;

  cv_seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_table (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (WR_EN),
    .wr_addr (WR_ADDR),
    .wr_dat  (WR_DAT),
    .rd_addr (nom),
    .rd_dat  (SEQ)
  );

endmodule

// File: doc/cv_gen_seq_prm.md
CV_GEN_SEQ_PRM -- requirements
Module: cv_gen_seq_prm

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, which sets the sequence value width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, which sets the table entries (2..256); IDX_W = clog2(DEPTH).
REQ-003 The block SHALL have port CLK  in  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST  in  1  a synchronous, active-high reset.
REQ-005 The block SHALL have port STEP  in  1  an advance enable, sampled on each CLK edge.
REQ-006 The block SHALL have port LOAD  in  1  which loads the index from DAT_I.
REQ-007 The block SHALL have port MODE  in  2  with encodings 00 up, 01 down, 10 ping-pong, 11 hold.
REQ-008 The block SHALL have port DAT_I  in  IDX_W  the load index.
REQ-009 The block SHALL have port LO  in  IDX_W  the lower window bound.
REQ-010 The block SHALL have port HI  in  IDX_W  the upper window bound.
REQ-011 The block SHALL have port WR_EN  in  1  the table write strobe (macro-gated, REQ-029).
REQ-012 The block SHALL have port WR_ADDR  in  IDX_W  the table write address.
REQ-013 The block SHALL have port WR_DAT  in  WIDTH  the table write data.
REQ-014 The block SHALL have port NOM  out  IDX_W  the current index (registered).
REQ-015 The block SHALL have port SEQ  out  WIDTH  table[NOM], read combinationally from the table registers.
REQ-016 The block SHALL have port WRAP  out  1  a one-cycle pulse on a window boundary event.

Function
REQ-017 The block SHALL use per-edge priority RST > LOAD > STEP; with none of them active, NOM, the direction flag and WRAP SHALL be held (WRAP=0).
REQ-018 The block SHALL form the effective window as [LO,HI] when LO<=HI, and as [0,DEPTH-1] when LO>HI or HI>DEPTH-1.
REQ-019 On LOAD, the block SHALL set NOM=DAT_I when DAT_I is inside the window, else NOM=LO_eff, with direction flag=up and WRAP=0.
REQ-020 With STEP=1 and MODE=00, the block SHALL advance NOM+1, and HI_eff SHALL go to LO_eff with WRAP=1 in the next cycle.
REQ-021 With STEP=1 and MODE=01, the block SHALL advance NOM-1, and LO_eff SHALL go to HI_eff with WRAP=1.
REQ-022 With STEP=1 and MODE=10, the block SHALL move in the direction of the flag; at HI_eff going up it SHALL reverse to NOM-1, at LO_eff going down it SHALL reverse to NOM+1; no endpoint is repeated; WRAP=1 on each reversal.
REQ-023 With STEP=1 and MODE=11, NOM SHALL be unchanged and WRAP=0.
REQ-024 When LO_eff==HI_eff and STEP=1 in modes 00/01/10, NOM SHALL stay constant and WRAP SHALL pulse every step.
REQ-025 When NOM lies outside a newly changed window at a STEP, the next NOM SHALL be LO_eff (up/ping-pong) or HI_eff (down), with WRAP=1.
REQ-026 A MODE change mid-run SHALL take effect on the next STEP from the current NOM; entering ping-pong SHALL keep the current direction flag.
REQ-027 A table write SHALL become visible on SEQ the cycle after the WR_EN edge, including when WR_ADDR==NOM; WR_ADDR>=DEPTH SHALL be ignored.

Reset
REQ-028 On RST=1 at a CLK edge, the block SHALL set NOM=0, direction flag=up, WRAP=0, and all table entries to the package default, so that SEQ=default[0]; reset SHALL override a simultaneous LOAD, STEP or WR_EN.

Configuration
REQ-029 The macro CV_GEN_SEQ_TABLE_WR_EN SHALL make the table a writable register file per REQ-027 when defined; when undefined, the table SHALL be the constant package ROM, WR_EN/WR_ADDR/WR_DAT SHALL remain as ports but be ignored, and no table registers SHALL be inferred.

Structure
REQ-030 A shared package cv_gen_seq_pkg SHALL hold the MODE encodings (MODE_UP, MODE_DN, MODE_PP, MODE_HOLD) and the default-table function (default[i] = Gray code of i, truncated to WIDTH).
REQ-031 The block SHALL contain one sub-module, cv_seq_table (table storage, write port, combinational read), instantiated once; index/direction control SHALL reside in cv_gen_seq_prm.

Verification
REQ-032 The bench SHALL check: RST, then MODE=00, STEP=1 for 17 cycles -> NOM 0..15,0; SEQ at NOM=5 equals 7; a single WRAP pulse on 15->0.
REQ-033 The bench SHALL check: LOAD with DAT_I=9, LO=4, HI=10, MODE=10, STEP=1 -> NOM 9,10,9,8,...,4,5; WRAP pulses at 10->9 and 4->5.
REQ-034 The bench SHALL check: LOAD with DAT_I=2 and window 4..10 -> NOM=4; LOAD+STEP asserted together -> LOAD wins.
REQ-035 The bench SHALL check: RST asserted mid-run with LOAD=1 and STEP=1 -> NOM=0, SEQ=0, WRAP=0 on the next cycle.
REQ-036 The bench SHALL check, with the macro defined: WR_EN, WR_ADDR=NOM=3, WR_DAT=0xA -> SEQ=0xA the next cycle; with the macro undefined, SEQ stays 2.
REQ-037 The bench SHALL check: LO=HI=6, MODE=01, STEP=1 -> NOM stays 6 and WRAP=1 every cycle; MODE=11 -> WRAP=0.
